sdram_read_arbiter: RTL and testbench

Two-requester round-robin scheduler for the SDRAM read master's control/user interface (read_base/read_length/go/done, read_buffer/data_available).
- Accepts burst-read commands from two clients.
- Launches them one at a time on the shared read master.
- Steers the returned word stream to the granted client with a valid/ready handshake.
- Signals per-request completion.
- Sits between the read master and display/DSP consumers.

---
 rtl/sdram_read_arbiter.sv | 179 +++++++++++++++++
 tb/tb_sdram_read_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_read_arbiter.sv
// sdram_read_arbiter
//    Two-client round-robin front end for the SDRAM read master. Each client
//    posts a burst read (byte base, byte length, fixed-location flag). Commands
//    are launched one at a time on the shared master control bus. The returned
//    word stream is steered to the granted client with a valid/ready handshake.
//
// Ports
//    clk_clk, reset_reset        clock, async active-high reset
//    reqN_valid/base/length/fixed  client N command (held until reqN_ack)
//    reqN_ack                    1-cycle pulse, command captured
//    reqN_data/data_valid/ready  word stream to client N
//    reqN_done                   1-cycle pulse, request complete
//    ctrl_*                      read master control bus (go/done/base/length)
//    ctrl_early_done             accepted but not used for sequencing
//    user_read_buffer            pop strobe to the read master FIFO
//    user_buffer_output_data     FIFO head word
//    user_data_available         FIFO not empty
//    busy                        transfer in progress
//    grant                       client owning the current/last transfer
//
// state  | meaning
// IDLE   | arbitrate; capture winner's command, pulse its ack
// LAUNCH | command registered; raise ctrl_go on the way out
// STREAM | forward words to the granted client until counter empty and done
// FINISH | pulse the granted client's done, then back to IDLE

module sdram_read_arbiter #(
   parameter int ADDR_W = 25,
   parameter int DATA_W = 16
) (
   input  logic              clk_clk,
   input  logic              reset_reset,

   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_base,
   input  logic [ADDR_W-1:0] req0_length,
   input  logic              req0_fixed,
   output logic              req0_ack,
   output logic [DATA_W-1:0] req0_data,
   output logic              req0_data_valid,
   input  logic              req0_data_ready,
   output logic              req0_done,

   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_base,
   input  logic [ADDR_W-1:0] req1_length,
   input  logic              req1_fixed,
   output logic              req1_ack,
   output logic [DATA_W-1:0] req1_data,
   output logic              req1_data_valid,
   input  logic              req1_data_ready,
   output logic              req1_done,

   output logic              ctrl_fixed_location,
   output logic [ADDR_W-1:0] ctrl_read_base,
   output logic [ADDR_W-1:0] ctrl_read_length,
   output logic              ctrl_go,
   input  logic              ctrl_done,
   input  logic              ctrl_early_done,

   output logic              user_read_buffer,
   input  logic [DATA_W-1:0] user_buffer_output_data,
   input  logic              user_data_available,

   output logic              busy,
   output logic              grant
);

   typedef enum logic [1:0] {IDLE, LAUNCH, STREAM, FINISH} state_t;

   state_t            state;
   logic [ADDR_W-1:0] word_cnt;
   logic              done_seen;
   logic              rr_last;

   logic              pick_valid;
   logic              pick;
   logic [ADDR_W-1:0] sel_base;
   logic [ADDR_W-1:0] sel_length;
   logic              sel_fixed;
   logic              streaming;
   logic              cnt_nz;
   logic              g_ready;
   logic              pop;
   logic              last_pop;
   logic              unused_early_done;

   assign unused_early_done = ctrl_early_done;

   // Tie goes to the client that did not win last time.
   always_comb begin
      pick_valid = req0_valid | req1_valid;
      if (req0_valid && req1_valid) pick = ~rr_last;
      else                          pick = req1_valid;
      sel_base   = pick ? req1_base   : req0_base;
      sel_length = pick ? req1_length : req0_length;
      sel_fixed  = pick ? req1_fixed  : req0_fixed;
   end

   assign streaming = (state == STREAM);
   assign cnt_nz    = (word_cnt != '0);
   assign g_ready   = grant ? req1_data_ready : req0_data_ready;

   // Never pop past the requested word count, even if the FIFO still has data.
   assign pop              = streaming & cnt_nz & user_data_available & g_ready;
   assign last_pop         = pop & (word_cnt == ADDR_W'(1));
   assign user_read_buffer = pop;

   assign req0_data_valid = streaming & cnt_nz & ~grant & user_data_available;
   assign req1_data_valid = streaming & cnt_nz &  grant & user_data_available;
   assign req0_data       = (streaming & ~grant) ? user_buffer_output_data : '0;
   assign req1_data       = (streaming &  grant) ? user_buffer_output_data : '0;

   assign busy = (state != IDLE);

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         state               <= IDLE;
         word_cnt            <= '0;
         done_seen           <= 1'b0;
         rr_last             <= 1'b1;
         grant               <= 1'b0;
         req0_ack            <= 1'b0;
         req1_ack            <= 1'b0;
         req0_done           <= 1'b0;
         req1_done           <= 1'b0;
         ctrl_go             <= 1'b0;
         ctrl_fixed_location <= 1'b0;
         ctrl_read_base      <= '0;
         ctrl_read_length    <= '0;
      end else begin
         req0_ack  <= 1'b0;
         req1_ack  <= 1'b0;
         req0_done <= 1'b0;
         req1_done <= 1'b0;
         ctrl_go   <= 1'b0;

         case (state)
            IDLE: begin
               if (pick_valid) begin
                  ctrl_read_base      <= sel_base;
                  ctrl_read_length    <= sel_length;
                  ctrl_fixed_location <= sel_fixed;
                  // Odd trailing byte is dropped: only whole words are moved.
                  word_cnt            <= sel_length >> 1;
                  grant               <= pick;
                  rr_last             <= pick;
                  if (pick) req1_ack <= 1'b1;
                  else      req0_ack <= 1'b1;
                  if (sel_length[ADDR_W-1:1] == '0) state <= FINISH;
                  else                              state <= LAUNCH;
               end
            end

            LAUNCH: begin
               ctrl_go   <= 1'b1;
               done_seen <= 1'b0;
               state     <= STREAM;
            end

            STREAM: begin
               if (pop)       word_cnt  <= word_cnt - ADDR_W'(1);
               if (ctrl_done) done_seen <= 1'b1;
               if ((last_pop || !cnt_nz) && (done_seen || ctrl_done))
                  state <= FINISH;
            end

            FINISH: begin
               if (grant) req1_done <= 1'b1;
               else       req0_done <= 1'b1;
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_read_arbiter.sv
module tb_sdram_read_arbiter;

   logic        clk_clk = 1'b0;
   logic        reset_reset;
   logic        req_valid [2];
   logic [24:0] req_base  [2];
   logic [24:0] req_len   [2];
   logic        req_fixed [2];
   logic        req_ready [2];
   wire  [1:0]  ack;
   wire  [1:0]  dv;
   wire  [1:0]  done;
   wire  [15:0] rdata [2];
   wire         ctrl_fixed_location;
   wire  [24:0] ctrl_read_base;
   wire  [24:0] ctrl_read_length;
   wire         ctrl_go;
   logic        ctrl_done;
   logic        ctrl_early_done;
   wire         user_read_buffer;
   logic [15:0] user_data;
   logic        user_avail;
   wire         busy;
   wire         grant;

   int checks   = 0;
   int failures = 0;

   always #5 clk_clk = ~clk_clk;

   sdram_read_arbiter dut (
      .clk_clk                 (clk_clk),
      .reset_reset             (reset_reset),
      .req0_valid              (req_valid[0]),
      .req0_base               (req_base[0]),
      .req0_length             (req_len[0]),
      .req0_fixed              (req_fixed[0]),
      .req0_ack                (ack[0]),
      .req0_data               (rdata[0]),
      .req0_data_valid         (dv[0]),
      .req0_data_ready         (req_ready[0]),
      .req0_done               (done[0]),
      .req1_valid              (req_valid[1]),
      .req1_base               (req_base[1]),
      .req1_length             (req_len[1]),
      .req1_fixed              (req_fixed[1]),
      .req1_ack                (ack[1]),
      .req1_data               (rdata[1]),
      .req1_data_valid         (dv[1]),
      .req1_data_ready         (req_ready[1]),
      .req1_done               (done[1]),
      .ctrl_fixed_location     (ctrl_fixed_location),
      .ctrl_read_base          (ctrl_read_base),
      .ctrl_read_length        (ctrl_read_length),
      .ctrl_go                 (ctrl_go),
      .ctrl_done               (ctrl_done),
      .ctrl_early_done         (ctrl_early_done),
      .user_read_buffer        (user_read_buffer),
      .user_buffer_output_data (user_data),
      .user_data_available     (user_avail),
      .busy                    (busy),
      .grant                   (grant)
   );

   task automatic step;
      @(posedge clk_clk);
      #1;
   endtask

   task automatic apply_reset;
      reset_reset = 1'b1;
      step();
      step();
      reset_reset = 1'b0;
      step();
   endtask

   // One complete transfer for client c. Word i carries 0xA000 + c*0x100 + i.
   // done_mode 0: ctrl_done on the last pop; 1: two cycles before last pop;
   // 2: only after the counter has drained.
   task automatic do_transfer(input int c, input logic [24:0] base, input logic [24:0] len,
                              input logic fx, input int nwords, input int done_mode,
                              input logic [15:0] rdy_pat);
      int o = 1 - c;
      int popped = 0;
      logic r;
      logic [15:0] exp_d;
      req_base[c]  = base;
      req_len[c]   = len;
      req_fixed[c] = fx;
      req_valid[c] = 1'b1;
      step();
      checks++; if (ack[c] !== 1'b1) begin failures++; $display("FAIL ack c=%0d got=%b exp=1", c, ack[c]); end
      checks++; if (ack[o] !== 1'b0) begin failures++; $display("FAIL ack_other c=%0d got=%b exp=0", c, ack[o]); end
      checks++; if (grant !== c[0]) begin failures++; $display("FAIL grant got=%b exp=%0d", grant, c); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_at_ack got=%b exp=1", busy); end
      req_valid[c] = 1'b0;
      if (nwords == 0) begin
         checks++; if (ctrl_go !== 1'b0) begin failures++; $display("FAIL go_len0 got=%b exp=0", ctrl_go); end
         step();
         checks++; if (done[c] !== 1'b1) begin failures++; $display("FAIL done_len0 c=%0d got=%b exp=1", c, done[c]); end
         checks++; if (ctrl_go !== 1'b0) begin failures++; $display("FAIL go_len0b got=%b exp=0", ctrl_go); end
         checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_len0 got=%b exp=0", busy); end
         return;
      end
      step();
      checks++; if (ctrl_go !== 1'b1) begin failures++; $display("FAIL go_pulse got=%b exp=1", ctrl_go); end
      checks++; if (ctrl_read_base !== base) begin failures++; $display("FAIL ctrl_base got=%h exp=%h", ctrl_read_base, base); end
      checks++; if (ctrl_read_length !== len) begin failures++; $display("FAIL ctrl_length got=%h exp=%h", ctrl_read_length, len); end
      checks++; if (ctrl_fixed_location !== fx) begin failures++; $display("FAIL ctrl_fixed got=%b exp=%b", ctrl_fixed_location, fx); end
      step();
      checks++; if (ctrl_go !== 1'b0) begin failures++; $display("FAIL go_one_cycle got=%b exp=0", ctrl_go); end
      for (int j = 0; j < 16 && popped < nwords; j++) begin
         r = rdy_pat[j];
         exp_d = 16'hA000 + 16'(c * 256) + 16'(popped);
         req_ready[c] = r;
         req_ready[o] = 1'b1;
         user_avail   = 1'b1;
         user_data    = exp_d;
         ctrl_done    = (done_mode == 0 && popped == nwords - 1 && r) ||
                        (done_mode == 1 && popped == nwords - 3);
         #1;
         checks++; if (user_read_buffer !== r) begin failures++; $display("FAIL read_buffer j=%0d got=%b exp=%b", j, user_read_buffer, r); end
         checks++; if (dv[c] !== 1'b1) begin failures++; $display("FAIL data_valid j=%0d got=%b exp=1", j, dv[c]); end
         checks++; if (rdata[c] !== exp_d) begin failures++; $display("FAIL data j=%0d got=%h exp=%h", j, rdata[c], exp_d); end
         checks++; if (dv[o] !== 1'b0) begin failures++; $display("FAIL other_valid j=%0d got=%b exp=0", j, dv[o]); end
         if (r) popped++;
         step();
      end
      checks++; if (popped != nwords) begin failures++; $display("FAIL word_count got=%0d exp=%0d", popped, nwords); end
      user_avail   = 1'b0;
      ctrl_done    = 1'b0;
      req_ready[0] = 1'b0;
      req_ready[1] = 1'b0;
      if (done_mode == 2) begin
         user_avail   = 1'b1;
         req_ready[c] = 1'b1;
         #1;
         checks++; if (user_read_buffer !== 1'b0) begin failures++; $display("FAIL overpop got=%b exp=0", user_read_buffer); end
         checks++; if (dv[c] !== 1'b0) begin failures++; $display("FAIL valid_after_last got=%b exp=0", dv[c]); end
         checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wait_done_busy got=%b exp=1", busy); end
         checks++; if (done[c] !== 1'b0) begin failures++; $display("FAIL early_finish got=%b exp=0", done[c]); end
         user_avail   = 1'b0;
         req_ready[c] = 1'b0;
         ctrl_done    = 1'b1;
         step();
         ctrl_done    = 1'b0;
      end
      checks++; if (busy !== 1'b1 || done[c] !== 1'b0) begin failures++; $display("FAIL finish_state busy=%b done=%b exp busy=1 done=0", busy, done[c]); end
      step();
      checks++; if (done[c] !== 1'b1) begin failures++; $display("FAIL done c=%0d got=%b exp=1", c, done[c]); end
      checks++; if (done[o] !== 1'b0) begin failures++; $display("FAIL done_other c=%0d got=%b exp=0", c, done[o]); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_end got=%b exp=0", busy); end
   endtask

   task automatic test_reset;
      apply_reset();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (ctrl_go !== 1'b0) begin failures++; $display("FAIL reset_go got=%b exp=0", ctrl_go); end
      checks++; if (grant !== 1'b0) begin failures++; $display("FAIL reset_grant got=%b exp=0", grant); end
      checks++; if (ack !== 2'b00 || done !== 2'b00) begin failures++; $display("FAIL reset_pulses ack=%b done=%b exp=00", ack, done); end
      checks++; if (ctrl_read_base !== 25'd0 || ctrl_read_length !== 25'd0) begin failures++; $display("FAIL reset_ctrl base=%h len=%h exp=0", ctrl_read_base, ctrl_read_length); end
      checks++; if (user_read_buffer !== 1'b0 || dv !== 2'b00) begin failures++; $display("FAIL reset_stream rb=%b dv=%b exp=0", user_read_buffer, dv); end
   endtask

   task automatic test_single;
      do_transfer(0, 25'h000100, 25'd8, 1'b0, 4, 0, 16'hFFFF);
   endtask

   task automatic test_round_robin;
      apply_reset();
      for (int k = 0; k < 2; k++) begin
         req_base[1] = 25'h004000; req_len[1] = 25'd4; req_fixed[1] = 1'b0;
         req_valid[1] = 1'b1;
         do_transfer(0, 25'h003000, 25'd4, 1'b0, 2, 0, 16'hFFFF);
         do_transfer(1, 25'h004000, 25'd4, 1'b0, 2, 0, 16'hFFFF);
      end
   endtask

   task automatic test_backpressure;
      do_transfer(1, 25'h010000, 25'd6, 1'b1, 3, 0, 16'hFFF9);
   endtask

   task automatic test_done_timing;
      do_transfer(0, 25'h000200, 25'd8, 1'b0, 4, 1, 16'hFFFF);
      do_transfer(1, 25'h000300, 25'd8, 1'b0, 4, 2, 16'hFFFF);
   endtask

   task automatic test_short_lengths;
      do_transfer(0, 25'h000400, 25'd0, 1'b0, 0, 0, 16'hFFFF);
      do_transfer(1, 25'h000500, 25'd1, 1'b0, 0, 0, 16'hFFFF);
      do_transfer(0, 25'h000600, 25'd5, 1'b0, 2, 0, 16'hFFFF);
   endtask

   task automatic test_reset_mid_stream;
      req_base[0] = 25'h000800; req_len[0] = 25'd8; req_fixed[0] = 1'b0;
      req_valid[0] = 1'b1;
      step();
      req_valid[0] = 1'b0;
      step();
      step();
      user_avail = 1'b1; req_ready[0] = 1'b1; user_data = 16'h1234;
      step();
      step();
      #1;
      checks++; if (user_read_buffer !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL pre_reset_stream rb=%b busy=%b exp=1", user_read_buffer, busy); end
      reset_reset = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL async_busy got=%b exp=0", busy); end
      checks++; if (ctrl_go !== 1'b0 || user_read_buffer !== 1'b0) begin failures++; $display("FAIL async_go_rb go=%b rb=%b exp=0", ctrl_go, user_read_buffer); end
      checks++; if (dv !== 2'b00) begin failures++; $display("FAIL async_valid got=%b exp=00", dv); end
      user_avail = 1'b0; req_ready[0] = 1'b0;
      step();
      reset_reset = 1'b0;
      step();
      do_transfer(1, 25'h002000, 25'd4, 1'b1, 2, 0, 16'hFFFF);
   endtask

   initial begin
      reset_reset     = 1'b1;
      ctrl_done       = 1'b0;
      ctrl_early_done = 1'b0;
      user_data       = 16'h0;
      user_avail      = 1'b0;
      for (int i = 0; i < 2; i++) begin
         req_valid[i] = 1'b0;
         req_base[i]  = '0;
         req_len[i]   = '0;
         req_fixed[i] = 1'b0;
         req_ready[i] = 1'b0;
      end
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_done_timing();
      test_short_lengths();
      test_reset_mid_stream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule
